// File: rtl/eth_tx_sched.sv
// Round-robin transmit frame scheduler for the shared RMII transmit path.
// Sequences preamble through IFG and drives the datapath mux, FIFO read strobe and CRC enable.
module eth_tx_sched #(
    parameter int pMIN_PAYLOAD = 46,
    parameter int pMAX_PAYLOAD = 1500,
    parameter int pIFG_CYC     = 48
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Eth_En,
    input  logic [1:0]  Req,
    input  logic [10:0] Req_Len0,
    input  logic [10:0] Req_Len1,
    output logic [1:0]  Grant,
    output logic [3:0]  Tx_Ctrl_FSM_State,
    output logic        Tx_En,
    output logic        Fifo_Rd,
    output logic        Crc_En,
    output logic        Frame_Done,
    output logic        Len_Err
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        PREAMBLE  = 4'd1,
        SFD       = 4'd2,
        DEST_ADDR = 4'd3,
        SRC_ADDR  = 4'd4,
        LEN_TYPE  = 4'd5,
        DATA      = 4'd6,
        PAD       = 4'd7,
        FCS       = 4'd8,
        IFG       = 4'd9
    } stateT;

    stateT       state;
    logic [12:0] cnt;
    logic [10:0] lenReg;
    logic        lastGrant;
    logic        winner;
    logic [10:0] winLen;
    logic        lenOk;
    logic        needPad;

    // Single requester wins outright; on contention the one not served last wins.
    always_comb begin
        winner = 1'b0;
        if (Req == 2'b10) begin
            winner = 1'b1;
        end else if (Req == 2'b11) begin
            winner = ~lastGrant;
        end
    end

    assign winLen  = winner ? Req_Len1 : Req_Len0;
    assign lenOk   = (winLen != 11'd0) && (winLen <= 11'(pMAX_PAYLOAD));
    assign needPad = lenReg < 11'(pMIN_PAYLOAD);

    // The counter holds (remaining cycles - 1) of the current state; a state ends when it hits zero.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= IDLE;
            cnt       <= '0;
            lenReg    <= '0;
            lastGrant <= 1'b1;
            Grant     <= 2'b00;
            Len_Err   <= 1'b0;
        end else begin
            Len_Err <= 1'b0;
            if (cnt != 13'd0) begin
                cnt <= cnt - 13'd1;
            end
            case (state)
                IDLE: begin
                    if (Eth_En && (Req != 2'b00)) begin
                        lastGrant <= winner;
                        lenReg    <= winLen;
                        if (lenOk) begin
                            Grant <= winner ? 2'b10 : 2'b01;
                            state <= PREAMBLE;
                            cnt   <= 13'd27;
                        end else begin
                            Len_Err <= 1'b1;
                        end
                    end
                end
                PREAMBLE: if (cnt == 13'd0) begin state <= SFD;       cnt <= 13'd3;  end
                SFD:      if (cnt == 13'd0) begin state <= DEST_ADDR; cnt <= 13'd23; end
                DEST_ADDR:if (cnt == 13'd0) begin state <= SRC_ADDR;  cnt <= 13'd23; end
                SRC_ADDR: if (cnt == 13'd0) begin state <= LEN_TYPE;  cnt <= 13'd7;  end
                LEN_TYPE: begin
                    if (cnt == 13'd0) begin
                        state <= DATA;
                        cnt   <= {lenReg, 2'b00} - 13'd1;
                    end
                end
                DATA: begin
                    if (cnt == 13'd0) begin
                        if (needPad) begin
                            state <= PAD;
                            cnt   <= 13'(4 * pMIN_PAYLOAD) - {lenReg, 2'b00} - 13'd1;
                        end else begin
                            state <= FCS;
                            cnt   <= 13'd15;
                        end
                    end
                end
                PAD:      if (cnt == 13'd0) begin state <= FCS; cnt <= 13'd15; end
                FCS: begin
                    if (cnt == 13'd0) begin
                        state <= IFG;
                        cnt   <= 13'(pIFG_CYC - 1);
                        Grant <= 2'b00;
                    end
                end
                IFG:      if (cnt == 13'd0) state <= IDLE;
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    Grant <= 2'b00;
                end
            endcase
        end
    end

    assign Tx_Ctrl_FSM_State = state;
    assign Tx_En      = (state >= PREAMBLE) && (state <= FCS);
    assign Crc_En     = (state >= DEST_ADDR) && (state <= PAD);
    // Strobe lands on the last dibit of each byte so the next byte is ready one cycle ahead.
    assign Fifo_Rd    = ((state == LEN_TYPE) && (cnt == 13'd0)) ||
                        ((state == DATA) && (cnt[1:0] == 2'b00) && (cnt != 13'd0));
    assign Frame_Done = (state == FCS) && (cnt == 13'd0);

endmodule

// File: tb/tb_eth_tx_sched.sv
// Scoreboard bench for eth_tx_sched: stimulus queues expected per-frame totals,
// a monitor accumulates what the DUT does and compares on Frame_Done / Len_Err.
module tb_eth_tx_sched;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Eth_En = 1'b0;
    logic [1:0]  Req = 2'b00;
    logic [10:0] Req_Len0 = '0;
    logic [10:0] Req_Len1 = '0;
    logic [1:0]  Grant;
    logic [3:0]  Tx_Ctrl_FSM_State;
    logic        Tx_En;
    logic        Fifo_Rd;
    logic        Crc_En;
    logic        Frame_Done;
    logic        Len_Err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         isLenErr;
        logic [1:0] grant;
        int         tx;
        int         rd;
        int         crc;
        int         pad;
    } expT;

    expT sb[$];

    eth_tx_sched dut (
        .Clk(Clk), .Rst(Rst), .Eth_En(Eth_En), .Req(Req),
        .Req_Len0(Req_Len0), .Req_Len1(Req_Len1), .Grant(Grant),
        .Tx_Ctrl_FSM_State(Tx_Ctrl_FSM_State), .Tx_En(Tx_En), .Fifo_Rd(Fifo_Rd),
        .Crc_En(Crc_En), .Frame_Done(Frame_Done), .Len_Err(Len_Err)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [1:0] r, input logic [10:0] l0, input logic [10:0] l1);
        Eth_En   = en;
        Req      = r;
        Req_Len0 = l0;
        Req_Len1 = l1;
    endtask

    task automatic pushFrame(input logic [1:0] g, input int tx, input int rd, input int crc, input int pad);
        expT e;
        e.isLenErr = 1'b0; e.grant = g; e.tx = tx; e.rd = rd; e.crc = crc; e.pad = pad;
        sb.push_back(e);
    endtask

    task automatic pushLenErr();
        expT e;
        e.isLenErr = 1'b1; e.grant = 2'b00; e.tx = 0; e.rd = 0; e.crc = 0; e.pad = 0;
        sb.push_back(e);
    endtask

    task automatic waitState(input logic [3:0] s, input int budget, input string name);
        int n = 0;
        bit found = 1'b0;
        while (!found && n < budget) begin
            @(negedge Clk);
            if (Tx_Ctrl_FSM_State == s) found = 1'b1;
            n++;
        end
        checkOutput(name, int'(found), 1);
    endtask

    task automatic waitFrameDone(input int budget, input string name);
        int n = 0;
        bit found = 1'b0;
        while (!found && n < budget) begin
            @(negedge Clk);
            if (Frame_Done) found = 1'b1;
            n++;
        end
        checkOutput(name, int'(found), 1);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_state"}, int'(Tx_Ctrl_FSM_State), 0);
        checkOutput({tag, "_grant"}, int'(Grant), 0);
        checkOutput({tag, "_txEn"}, int'(Tx_En), 0);
        checkOutput({tag, "_fifoRd"}, int'(Fifo_Rd), 0);
        checkOutput({tag, "_crcEn"}, int'(Crc_En), 0);
        checkOutput({tag, "_frameDone"}, int'(Frame_Done), 0);
        checkOutput({tag, "_lenErr"}, int'(Len_Err), 0);
    endtask

    // Monitor state
    int         txCnt = 0, rdCnt = 0, crcCnt = 0, padCnt = 0;
    int         ifgCnt = 0, gapCnt = 0;
    bit         ended = 1'b0;
    logic [1:0] grantSeen = 2'b00;
    logic [3:0] prevState = 4'd0;

    initial begin
        expT e;
        forever begin
            @(posedge Clk);
            #1;
            if (prevState == 4'd9 && Tx_Ctrl_FSM_State != 4'd9) checkOutput("ifgLength", ifgCnt, 48);
            if (Tx_Ctrl_FSM_State == 4'd9) ifgCnt++; else ifgCnt = 0;
            if (Tx_Ctrl_FSM_State == 4'd0) begin
                txCnt = 0; rdCnt = 0; crcCnt = 0; padCnt = 0;
            end
            if (Tx_En) begin
                if (txCnt == 0) begin
                    grantSeen = Grant;
                    if (ended) checkOutput("interFrameGap", int'(gapCnt >= 49), 1);
                end
                txCnt++;
            end else begin
                gapCnt++;
            end
            if (Fifo_Rd) rdCnt++;
            if (Crc_En) crcCnt++;
            if (Tx_Ctrl_FSM_State == 4'd7) padCnt++;
            if (Frame_Done) begin
                checkOutput("sbNonEmptyFrame", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    checkOutput("frameKind", int'(e.isLenErr), 0);
                    checkOutput("frameGrant", int'(grantSeen), int'(e.grant));
                    checkOutput("frameTxEn", txCnt, e.tx);
                    checkOutput("frameFifoRd", rdCnt, e.rd);
                    checkOutput("frameCrcEn", crcCnt, e.crc);
                    checkOutput("framePad", padCnt, e.pad);
                end
                ended  = 1'b1;
                gapCnt = 0;
            end
            if (Len_Err) begin
                checkOutput("sbNonEmptyLenErr", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    checkOutput("lenErrKind", int'(e.isLenErr), 1);
                end
                checkOutput("lenErrTxEn", int'(Tx_En), 0);
                checkOutput("lenErrGrant", int'(Grant), 0);
            end
            prevState = Tx_Ctrl_FSM_State;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int busy;
        repeat (3) @(negedge Clk);
        checkAllZero("reset");
        Rst = 1'b0;

        // Single requester at the minimum payload: no PAD.
        @(negedge Clk);
        pushFrame(2'b01, 288, 46, 240, 0);
        applyStimulus(1'b1, 2'b01, 11'd46, 11'd0);
        waitFrameDone(600, "t1FrameDone");
        applyStimulus(1'b1, 2'b00, 11'd46, 11'd0);
        waitState(4'd0, 200, "t1Idle");

        // One-byte payload: 180 PAD cycles.
        pushFrame(2'b10, 288, 1, 240, 180);
        applyStimulus(1'b1, 2'b10, 11'd0, 11'd1);
        waitFrameDone(600, "t2FrameDone");
        applyStimulus(1'b1, 2'b00, 11'd0, 11'd1);
        waitState(4'd0, 200, "t2Idle");

        // Both requesting: alternate grants, requester 1 was served last.
        pushFrame(2'b01, 344, 60, 296, 0);
        pushFrame(2'b10, 344, 60, 296, 0);
        pushFrame(2'b01, 344, 60, 296, 0);
        applyStimulus(1'b1, 2'b11, 11'd60, 11'd60);
        waitFrameDone(700, "t3FrameDoneA");
        waitFrameDone(700, "t3FrameDoneB");
        waitFrameDone(700, "t3FrameDoneC");
        applyStimulus(1'b1, 2'b00, 11'd60, 11'd60);
        waitState(4'd0, 200, "t3Idle");

        // Length errors: zero and above maximum.
        pushLenErr();
        applyStimulus(1'b1, 2'b01, 11'd0, 11'd0);
        @(negedge Clk);
        applyStimulus(1'b1, 2'b00, 11'd0, 11'd0);
        repeat (3) @(negedge Clk);
        pushLenErr();
        applyStimulus(1'b1, 2'b01, 11'd1501, 11'd0);
        @(negedge Clk);
        applyStimulus(1'b1, 2'b00, 11'd1501, 11'd0);
        repeat (3) @(negedge Clk);
        checkOutput("t4TxEn", int'(Tx_En), 0);
        checkOutput("t4Grant", int'(Grant), 0);

        // Reset in the 10th DATA cycle aborts the frame.
        applyStimulus(1'b1, 2'b01, 11'd46, 11'd46);
        begin
            int dataCycles = 0;
            int n = 0;
            while (dataCycles < 10 && n < 400) begin
                @(negedge Clk);
                if (Tx_Ctrl_FSM_State == 4'd6) dataCycles++;
                n++;
            end
            checkOutput("t5ReachData10", dataCycles, 10);
        end
        Rst = 1'b1;
        applyStimulus(1'b1, 2'b00, 11'd46, 11'd46);
        @(negedge Clk);
        checkAllZero("midReset");
        Rst = 1'b0;
        @(negedge Clk);
        // Pointer must be back at requester 1, so requester 0 wins the tie.
        pushFrame(2'b01, 288, 46, 240, 0);
        applyStimulus(1'b1, 2'b11, 11'd46, 11'd46);
        waitFrameDone(600, "t5FrameDone");
        applyStimulus(1'b1, 2'b00, 11'd46, 11'd46);
        waitState(4'd0, 200, "t5Idle");

        // Eth_En dropped mid-frame: frame completes, then nothing new starts.
        pushFrame(2'b01, 288, 20, 240, 104);
        applyStimulus(1'b1, 2'b01, 11'd20, 11'd60);
        waitState(4'd4, 200, "t6SrcAddr");
        Eth_En = 1'b0;
        waitFrameDone(600, "t6FrameDone");
        applyStimulus(1'b0, 2'b11, 11'd20, 11'd60);
        busy = 0;
        repeat (400) begin
            @(negedge Clk);
            if (Tx_En || (Grant != 2'b00)) busy++;
        end
        checkOutput("t6NoGrantEthEnLow", busy, 0);
        applyStimulus(1'b0, 2'b00, 11'd20, 11'd60);
        repeat (5) @(negedge Clk);

        checkOutput("scoreboardEmpty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
